// File: rtl/pe_window_feeder.sv
// pe_window_feeder: two-entry window buffer feeding the PE, with output-pixel tracking, frame-end pulse and starvation stats
module pe_window_feeder #(
  parameter int IN_WIDTH   = 513,
  parameter int IN_HEIGHT  = 257,
  parameter int IN_CHANNEL = 3,
  parameter int KERNEL_0   = 3,
  parameter int KERNEL_1   = 3,
  parameter int DILATION_0 = 2,
  parameter int DILATION_1 = 2,
  parameter int PADDING_0  = 2,
  parameter int PADDING_1  = 2,
  parameter int STRIDE_0   = 1,
  parameter int STRIDE_1   = 1,
  localparam int WIN_W = 8 * IN_CHANNEL * KERNEL_0 * KERNEL_1,
  localparam int OUT_W = (IN_WIDTH + 2 * PADDING_1 - DILATION_1 * (KERNEL_1 - 1) - 1) / STRIDE_1 + 1,
  localparam int OUT_H = (IN_HEIGHT + 2 * PADDING_0 - DILATION_0 * (KERNEL_0 - 1) - 1) / STRIDE_0 + 1,
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1,
  localparam int RW = OUT_H > 1 ? $clog2(OUT_H) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIN_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIN_W-1:0] i_data,
  output logic             i_valid,
  input  logic             pe_ready,
  input  logic             pe_ack,
  output logic [CW-1:0]    win_col,
  output logic [RW-1:0]    win_row,
  output logic             frame_done,
  output logic [31:0]      underrun_cnt,
  output logic             proto_err
);
  logic [1:0] count, count_next;
  logic wr_ptr, rd_ptr, push, pop, last_col, last_row;
  logic [WIN_W-1:0] mem [2];
  always_comb begin
    push = s_valid && s_ready;
    pop = pe_ack && i_valid;
    count_next = count + {1'b0, push} - {1'b0, pop};
    last_col = win_col == CW'(OUT_W - 1);
    last_row = win_row == RW'(OUT_H - 1);
    i_valid = count != 2'd0;
    i_data = mem[rd_ptr];
  end
  // storage is deliberately left unreset; count gates its visibility
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      s_ready <= 1'b0;
      win_col <= '0;
      win_row <= '0;
      frame_done <= 1'b0;
      underrun_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      count <= count_next;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      s_ready <= count_next < 2'd2;
      frame_done <= pop && last_col && last_row;
      proto_err <= proto_err | (pe_ack && !i_valid);
      underrun_cnt <= underrun_cnt + 32'(pe_ready && count == 2'd0 && underrun_cnt != '1);
      if (pop) begin
        win_col <= last_col ? '0 : win_col + 1'b1;
        win_row <= last_col ? (last_row ? '0 : win_row + 1'b1) : win_row;
      end
    end
endmodule

// File: tb/tb_pe_window_feeder.sv
// tb_pe_window_feeder: directed scenario tests for pe_window_feeder on a 4x3 output frame
module tb_pe_window_feeder;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [71:0] s_data = '0, i_data;
  logic s_valid = 1'b0, s_ready, i_valid, pe_ready = 1'b0, pe_ack = 1'b0;
  logic [1:0] win_col, win_row;
  logic frame_done, proto_err;
  logic [31:0] underrun_cnt;
  int checks = 0, failures = 0;
  localparam logic [71:0] W1 = {9{8'h11}}, W2 = {9{8'h22}}, W3 = {9{8'h33}}, WAB = {9{8'hAB}};

  pe_window_feeder #(
    .IN_WIDTH(4), .IN_HEIGHT(3), .IN_CHANNEL(1), .KERNEL_0(3), .KERNEL_1(3),
    .DILATION_0(1), .DILATION_1(1), .PADDING_0(1), .PADDING_1(1), .STRIDE_0(1), .STRIDE_1(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .i_data(i_data), .i_valid(i_valid), .pe_ready(pe_ready), .pe_ack(pe_ack),
    .win_col(win_col), .win_row(win_row), .frame_done(frame_done),
    .underrun_cnt(underrun_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL reset_i_valid got=%b exp=0", i_valid); end
    checks++; if ({win_row, win_col} !== 4'd0) begin failures++; $display("FAIL reset_coords got=%0d/%0d exp=0/0", win_row, win_col); end
    checks++; if ({frame_done, proto_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", frame_done, proto_err); end
    checks++; if (underrun_cnt !== 32'd0) begin failures++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_single();
    s_data = WAB; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checks++; if (i_valid !== 1'b1 || i_data !== WAB) begin failures++; $display("FAIL single_present got=%b/%h exp=1/%h", i_valid, i_data, WAB); end
    step();
    step();
    checks++; if (i_valid !== 1'b1 || i_data !== WAB) begin failures++; $display("FAIL single_hold got=%b/%h exp=1/%h", i_valid, i_data, WAB); end
    pe_ack = 1'b1;
    step();
    pe_ack = 1'b0;
    checks++; if (win_col !== 2'd1) begin failures++; $display("FAIL single_col got=%0d exp=1", win_col); end
    checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", i_valid); end
  endtask

  task automatic test_starve_err();
    pe_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    pe_ready = 1'b0;
    checks++; if (underrun_cnt !== 32'd10) begin failures++; $display("FAIL underrun got=%0d exp=10", underrun_cnt); end
    pe_ack = 1'b1;
    step();
    pe_ack = 1'b0;
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_err got=%b exp=1", proto_err); end
    checks++; if (win_col !== 2'd1 || i_valid !== 1'b0) begin failures++; $display("FAIL proto_no_pop got=%0d/%b exp=1/0", win_col, i_valid); end
    step();
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
  endtask

  task automatic test_back_pressure();
    s_valid = 1'b1; s_data = W1;
    step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", s_ready); end
    s_data = W2;
    step();
    checks++; if (s_ready !== 1'b0 || i_data !== W1) begin failures++; $display("FAIL bp_full got=%b/%h exp=0/%h", s_ready, i_data, W1); end
    s_data = W3;
    step();
    checks++; if (s_ready !== 1'b0 || i_data !== W1 || i_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/%h", s_ready, i_valid, i_data, W1); end
    s_valid = 1'b0; pe_ack = 1'b1;
    step();
    checks++; if (i_data !== W2 || s_ready !== 1'b1) begin failures++; $display("FAIL bp_drain1 got=%h/%b exp=%h/1", i_data, s_ready, W2); end
    step();
    pe_ack = 1'b0;
    checks++; if (i_valid !== 1'b0 || win_col !== 2'd3) begin failures++; $display("FAIL bp_drain2 got=%b/%0d exp=0/3", i_valid, win_col); end
  endtask

  task automatic test_concurrent();
    s_valid = 1'b1; s_data = W1;
    step();
    s_data = W2; pe_ack = 1'b1;
    step();
    s_valid = 1'b0; pe_ack = 1'b0;
    checks++; if (i_data !== W2 || i_valid !== 1'b1 || s_ready !== 1'b1) begin failures++; $display("FAIL conc_head got=%h/%b/%b exp=%h/1/1", i_data, i_valid, s_ready, W2); end
    checks++; if (win_row !== 2'd1 || win_col !== 2'd0) begin failures++; $display("FAIL conc_wrap got=%0d/%0d exp=1/0", win_row, win_col); end
    pe_ack = 1'b1;
    step();
    pe_ack = 1'b0;
    checks++; if (i_valid !== 1'b0 || win_col !== 2'd1) begin failures++; $display("FAIL conc_pop got=%b/%0d exp=0/1", i_valid, win_col); end
  endtask

  task automatic test_full_frame();
    int pulses;
    pulses = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      s_valid = 1'b1; s_data = 72'(k + 100);
      step();
      s_valid = 1'b0;
      checks++; if (i_data !== 72'(k + 100) || {win_row, win_col} !== 4'(((k / 4) << 2) | (k % 4))) begin failures++; $display("FAIL frame_win%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, i_data, win_row, win_col, k + 100, k / 4, k % 4); end
      step();
      pe_ack = 1'b1;
      step();
      pe_ack = 1'b0;
      if (frame_done === 1'b1) pulses++;
      checks++; if (frame_done !== (k == 11)) begin failures++; $display("FAIL frame_done%0d got=%b exp=%b", k, frame_done, k == 11); end
    end
    step();
    checks++; if (frame_done !== 1'b0 || pulses != 1) begin failures++; $display("FAIL frame_pulse got=%b/%0d exp=0/1", frame_done, pulses); end
    checks++; if ({win_row, win_col} !== 4'd0) begin failures++; $display("FAIL frame_wrap got=%0d/%0d exp=0/0", win_row, win_col); end
    s_valid = 1'b1; s_data = W3;
    step();
    checks++; if (i_valid !== 1'b1 || i_data !== W3 || {win_row, win_col} !== 4'd0) begin failures++; $display("FAIL frame_next got=%b/%h/%0d/%0d exp=1/%h/0/0", i_valid, i_data, win_row, win_col, W3); end
    s_data = W1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    checks++; if (s_ready !== 1'b0 || i_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b/%b exp=0/1", s_ready, i_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (i_valid !== 1'b0 || s_ready !== 1'b0 || underrun_cnt !== 32'd0 || {win_row, win_col} !== 4'd0) begin failures++; $display("FAIL mid_async got=%b/%b/%0d/%0d/%0d exp=0/0/0/0/0", i_valid, s_ready, underrun_cnt, win_row, win_col); end
    rst_n = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1 || i_valid !== 1'b0) begin failures++; $display("FAIL mid_release got=%b/%b exp=1/0", s_ready, i_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_starve_err();
    test_back_pressure();
    test_concurrent();
    test_full_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_window_feeder.md
Name: pe_window_feeder

Overview:
- Upstream-side initiator for the processing-element (PE) input handshake.
- Accepts pre-formed convolution windows from the window generator over a valid/ready stream.
- Buffers up to two windows and presents the head window to the PE on i_data/i_valid until the PE acknowledges it with pe_ack.
- Tracks the output-pixel coordinates of each issued window, flags end of frame, and counts PE starvation cycles.

Parameters:
IN_WIDTH, 513, input feature-map width
IN_HEIGHT, 257, input feature-map height
IN_CHANNEL, 3, input channels per window point
KERNEL_0, 3, kernel size along height
KERNEL_1, 3, kernel size along width
DILATION_0, 2, dilation along height
DILATION_1, 2, dilation along width
PADDING_0, 2, padding along height
PADDING_1, 2, padding along width
STRIDE_0, 1, stride along height
STRIDE_1, 1, stride along width
(derived) WIN_W = 8*IN_CHANNEL*KERNEL_0*KERNEL_1
(derived) OUT_W = (IN_WIDTH + 2*PADDING_1 - DILATION_1*(KERNEL_1-1) - 1)/STRIDE_1 + 1
(derived) OUT_H = the same formula using the _0 parameters
(derived) defaults give OUT_W = 513, OUT_H = 257

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_data  in  WIN_W  upstream window; packing identical to the PE i_data
s_valid  in  1  upstream window valid
s_ready  out  1  feeder can accept a window
i_data  out  WIN_W  head window presented to the PE
i_valid  out  1  head window valid
pe_ready  in  1  PE idle
pe_ack  in  1  PE captured i_data at this clock edge
win_col  out  clog2(OUT_W)  output column of the head window
win_row  out  clog2(OUT_H)  output row of the head window
frame_done  out  1  one-cycle pulse after the last window of a frame is acknowledged
underrun_cnt  out  32  count of cycles the PE was starved
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous) values:
  - occupancy count = 0; write and read pointers = 0.
  - s_ready = 0, i_valid = 0.
  - win_col = 0, win_row = 0.
  - frame_done = 0, underrun_cnt = 0, proto_err = 0.
  - Buffer contents are not reset.
- Storage: 2-entry circular buffer of WIN_W-bit entries; occupancy count is 0..2.
- s_ready is registered: next value = (count_next < 2). It is therefore 1 from the first clock after reset release, with no combinational path from pe_ack.
- Push: s_valid && s_ready at a clock edge writes s_data to the write pointer; the write pointer toggles.
- i_valid = (count != 0) and i_data = entry[read pointer]. Both come straight from registers/storage and are stable while waiting.
- Pop: pe_ack && i_valid at a clock edge.
  - The read pointer toggles.
  - The next entry, if present, appears on i_data in the following cycle.
  - Latency from push to i_valid, for an empty buffer: 1 cycle.
- Handshake rules:
  - i_data is held unchanged up to and including the edge where pe_ack = 1.
  - i_valid is never withdrawn before pe_ack.
  - i_valid is asserted regardless of pe_ready; pe_ready is used only for statistics.
- Simultaneous push and pop:
  - count = 1: count stays 1; the newly pushed entry becomes the head.
  - count = 2: push is impossible (s_ready = 0).
  - count = 0: only a push can occur.
- pe_ack with i_valid = 0: no pop, pointers and counters unchanged, proto_err set to 1. proto_err clears only on reset.
- Coordinate counters advance on each pop:
  - win_col increments.
  - At OUT_W-1, win_col wraps to 0 and win_row increments.
  - At win_row = OUT_H-1 and win_col = OUT_W-1, both wrap to 0.
- frame_done: registered 1 in the cycle after the pop of window (OUT_H-1, OUT_W-1); 0 otherwise.
- The next frame's windows stream back-to-back with no gap required.
- underrun_cnt increments each cycle where pe_ready = 1 and count = 0. It saturates at 32'hFFFF_FFFF.
- Reset mid-operation: all state returns to its reset values immediately; buffered windows are discarded.

Test Plan:
Use IN_WIDTH=4, IN_HEIGHT=3, IN_CHANNEL=1, K=3, D=1, P=1, S=1 for all scenarios, giving OUT_W=4, OUT_H=3, 12 windows, WIN_W=72.
- Single window: push 0xAB..AB with the PE acking 3 cycles after i_valid rises -> i_valid high 1 cycle after the push; i_data stable until the ack edge; win_col 0->1 after the ack; i_valid 0 afterwards.
- Back-pressure: push 3 windows back-to-back with pe_ack held 0 -> s_ready drops after the 2nd push; the 3rd is held by upstream; count=2; i_data = 1st window.
- Concurrent push and pop at count=1: push W2 in the same edge W1 is acked -> the next cycle i_data=W2, i_valid=1, s_ready=1.
- Full frame: stream 12 windows, each acked 1 cycle after presentation -> frame_done pulses exactly once, one cycle after the 12th ack; win_row/win_col read 0/0; the 13th window is reported as (0,0).
- Starvation and errors:
  - Hold pe_ready=1 with no input for 10 cycles -> underrun_cnt=10.
  - Pulse pe_ack with count=0 -> proto_err=1, win_col unchanged.
- Reset mid-stream: assert rst_n=0 with 2 windows buffered -> i_valid=0, s_ready=0, counters 0 asynchronously; s_ready=1 one clock after release.
